// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, addresses the
// combinational instruction memory and loads the IF/ID pipeline register.
// Priority per edge: branch redirect, stall, flush, halted, normal fetch.
module fetch_stage #(
    parameter int                   ADDR_W    = 22,
    parameter int                   INSTR_W   = 22,
    parameter int                   LAST_ADDR = 400,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = {INSTR_W{1'b0}},
    parameter int                   CNT_W     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall_f,
    input  logic                flush_d,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_rd,
    output logic [ADDR_W-1:0]   pc,
    output logic [INSTR_W-1:0]  instr_d,
    output logic [ADDR_W-1:0]   pc_d,
    output logic [ADDR_W-1:0]   pcplus4_d,
    output logic                valid_d,
    output logic                halted,
    output logic [CNT_W-1:0]    fetch_count
);

    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [ADDR_W-1:0]  fetch_pc_q,   fetch_pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc_q,    ifid_pc_d;
    logic [ADDR_W-1:0]  ifid_pc4_q,   ifid_pc4_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic               halted_q,     halted_d;
    logic [CNT_W-1:0]   fetch_cnt_q,  fetch_cnt_d;
    logic [ADDR_W-1:0]  pc_plus4_s;

    // Next-state selection for the PC, IF/ID register, halt flag and counter.
    always_comb begin
        pc_plus4_s   = fetch_pc_q + PC_STEP;
        fetch_pc_d   = fetch_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        halted_d     = halted_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (branch_taken) begin
            // Redirect always wins; target is forced word-aligned.
            fetch_pc_d   = {branch_target[ADDR_W-1:2], 2'b00};
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            halted_d     = 1'b0;
        end else if (stall_f) begin
            // Everything holds (defaults).
            fetch_pc_d = fetch_pc_q;
        end else if (flush_d) begin
            if (!halted_q) begin
                fetch_pc_d = pc_plus4_s;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (halted_q) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (fetch_pc_q > LAST_A) begin
            // Landed beyond the program (e.g. via a branch): stop without delivering.
            halted_d     = 1'b1;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else begin
            ifid_instr_d = imem_rd;
            ifid_pc_d    = fetch_pc_q;
            ifid_pc4_d   = pc_plus4_s;
            ifid_valid_d = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + CNT_ONE;
            if (pc_plus4_s > LAST_A) begin
                // Last word delivered; PC parks on it.
                halted_d   = 1'b1;
                fetch_pc_d = fetch_pc_q;
            end else begin
                fetch_pc_d = pc_plus4_s;
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q   <= {ADDR_W{1'b0}};
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= {ADDR_W{1'b0}};
            ifid_pc4_q   <= {ADDR_W{1'b0}};
            ifid_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            fetch_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            halted_q     <= halted_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign pc          = fetch_pc_q;
    assign instr_d     = ifid_instr_q;
    assign pc_d        = ifid_pc_q;
    assign pcplus4_d   = ifid_pc4_q;
    assign valid_d     = ifid_valid_q;
    assign halted      = halted_q;
    assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: expected snapshots are queued before
// each clock edge and compared against the DUT outputs after it.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_f = 1'b0;
    logic        flush_d = 1'b0;
    logic        branch_taken = 1'b0;
    logic [21:0] branch_target = 22'h0;
    logic [21:0] imem_addr;
    logic [21:0] imem_rd;
    logic [21:0] pc;
    logic [21:0] instr_d;
    logic [21:0] pc_d;
    logic [21:0] pcplus4_d;
    logic        valid_d;
    logic        halted;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [21:0] pc;
        logic [21:0] instr;
        logic [21:0] pcd;
        logic [21:0] pc4;
        logic        valid;
        logic        halted;
        logic [31:0] cnt;
    } obs_t;

    obs_t sb[$];
    int   total = 0;
    int   bad = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall_f(stall_f), .flush_d(flush_d),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rd(imem_rd), .pc(pc), .instr_d(instr_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .valid_d(valid_d),
        .halted(halted), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents by byte address.
    function automatic logic [21:0] mem_word(input logic [21:0] a);
        logic [19:0] w;
        w = a[21:2];
        case (w)
            20'd0:   return 22'h26808;
            20'd1:   return 22'h26808;
            20'd2:   return 22'h26809;
            20'd3:   return 22'h268B2;
            default: return 22'h300000 | {2'b00, w};
        endcase
    endfunction

    assign imem_rd = mem_word(imem_addr);

    function automatic obs_t mk(input logic [21:0] p, input logic [21:0] i,
                                input logic [21:0] pd, input logic [21:0] p4,
                                input logic v, input logic h, input logic [31:0] c);
        obs_t o;
        o.pc = p; o.instr = i; o.pcd = pd; o.pc4 = p4;
        o.valid = v; o.halted = h; o.cnt = c;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(pc, instr_d, pc_d, pcplus4_d, valid_d, halted, fetch_count);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        stall_f = 1'b0; flush_d = 1'b0; branch_taken = 1'b0; branch_target = 22'h0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got, e;
        #1;
        sb.push_back(mk(22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 1'b0, 32'd0));
        got = sample();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", got, e);
        end
        #2;
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        obs_t got, e;
        logic [21:0] p;
        for (int i = 0; i < 4; i++) begin
            p = 22'(4 * i);
            sb.push_back(mk(p + 22'd4, mem_word(p), p, p + 22'd4, 1'b1, 1'b0, 32'(i + 1)));
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL free_run[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_stall();
        obs_t got, e;
        do_reset();
        sb.push_back(mk(22'd4, 22'h26808, 22'd0, 22'd4, 1'b1, 1'b0, 32'd1));
        sb.push_back(mk(22'd8, 22'h26808, 22'd4, 22'd8, 1'b1, 1'b0, 32'd2));
        sb.push_back(mk(22'd8, 22'h26808, 22'd4, 22'd8, 1'b1, 1'b0, 32'd2));
        sb.push_back(mk(22'd8, 22'h26808, 22'd4, 22'd8, 1'b1, 1'b0, 32'd2));
        sb.push_back(mk(22'd12, 22'h26809, 22'd8, 22'd12, 1'b1, 1'b0, 32'd3));
        for (int i = 0; i < 5; i++) begin
            stall_f = (i == 2 || i == 3);
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL stall[%0d] got=%h exp=%h", i, got, e);
            end
        end
        stall_f = 1'b0;
    endtask

    // Continues from test_stall: pc=12, pc_d=8, count=3.
    task automatic test_branch();
        obs_t got, e;
        sb.push_back(mk(22'h28, 22'h0, 22'd8, 22'd12, 1'b0, 1'b0, 32'd3));
        sb.push_back(mk(22'h2C, mem_word(22'h28), 22'h28, 22'h2C, 1'b1, 1'b0, 32'd4));
        for (int i = 0; i < 2; i++) begin
            stall_f = (i == 0);
            branch_taken = (i == 0);
            branch_target = 22'h2A;
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL branch[%0d] got=%h exp=%h", i, got, e);
            end
        end
        stall_f = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic test_flush();
        obs_t got, e;
        do_reset();
        sb.push_back(mk(22'd4, 22'h26808, 22'd0, 22'd4, 1'b1, 1'b0, 32'd1));
        sb.push_back(mk(22'd8, 22'h26808, 22'd4, 22'd8, 1'b1, 1'b0, 32'd2));
        sb.push_back(mk(22'd12, 22'h26809, 22'd8, 22'd12, 1'b1, 1'b0, 32'd3));
        sb.push_back(mk(22'd16, 22'h0, 22'd8, 22'd12, 1'b0, 1'b0, 32'd3));
        sb.push_back(mk(22'd20, 22'h300004, 22'd16, 22'd20, 1'b1, 1'b0, 32'd4));
        for (int i = 0; i < 5; i++) begin
            flush_d = (i == 3);
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL flush[%0d] got=%h exp=%h", i, got, e);
            end
        end
        flush_d = 1'b0;
    endtask

    task automatic test_halt();
        obs_t got, e;
        logic [21:0] p;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            p = 22'(4 * i);
            sb.push_back(mk(p + 22'd4, mem_word(p), p, p + 22'd4, 1'b1, 1'b0, 32'(i + 1)));
        end
        sb.push_back(mk(22'd400, 22'h300064, 22'd400, 22'd404, 1'b1, 1'b1, 32'd101));
        sb.push_back(mk(22'd400, 22'h0, 22'd400, 22'd404, 1'b0, 1'b1, 32'd101));
        sb.push_back(mk(22'd400, 22'h0, 22'd400, 22'd404, 1'b0, 1'b1, 32'd101));
        sb.push_back(mk(22'd0, 22'h0, 22'd400, 22'd404, 1'b0, 1'b0, 32'd101));
        sb.push_back(mk(22'd4, 22'h26808, 22'd0, 22'd4, 1'b1, 1'b0, 32'd102));
        for (int i = 0; i < 105; i++) begin
            branch_taken = (i == 103);
            branch_target = 22'h0;
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL halt[%0d] got=%h exp=%h", i, got, e);
            end
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_branch_past_end();
        obs_t got, e;
        do_reset();
        sb.push_back(mk(22'h200, 22'h0, 22'h0, 22'h0, 1'b0, 1'b0, 32'd0));
        sb.push_back(mk(22'h200, 22'h0, 22'h0, 22'h0, 1'b0, 1'b1, 32'd0));
        sb.push_back(mk(22'h200, 22'h0, 22'h0, 22'h0, 1'b0, 1'b1, 32'd0));
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 0);
            branch_target = 22'h201;
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL past_end[%0d] got=%h exp=%h", i, got, e);
            end
        end
        branch_taken = 1'b0;
    endtask

    task automatic test_async_reset();
        obs_t got, e;
        logic [21:0] p;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            p = 22'(4 * i);
            sb.push_back(mk(p + 22'd4, mem_word(p), p, p + 22'd4, 1'b1, 1'b0, 32'(i + 1)));
            cyc();
            got = sample();
            e = sb.pop_front();
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL pre_areset[%0d] got=%h exp=%h", i, got, e);
            end
        end
        #2;
        reset = 1'b1;
        #1;
        sb.push_back(mk(22'h0, 22'h0, 22'h0, 22'h0, 1'b0, 1'b0, 32'd0));
        got = sample();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", got, e);
        end
        #1;
        reset = 1'b0;
        sb.push_back(mk(22'd4, 22'h26808, 22'd0, 22'd4, 1'b1, 1'b0, 32'd1));
        cyc();
        got = sample();
        e = sb.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL restart got=%h exp=%h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_flush();
        test_halt();
        test_branch_past_end();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
